maxpool2x2_mem: RTL

//  Memory-to-memory 2x2 stride-2 max-pooling stage; downstream consumer of the element-wise residual adder.

---
 rtl/cnn_pkg.sv | 16 +
 rtl/maxpool2x2_mem_if.sv | 16 +
 rtl/maxpool_addr_gen.sv | 90 +++++++++
 rtl/maxpool2x2_mem.sv | 118 +++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared defaults, pool FSM state codes and tap index type
package cnn_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_DIM_W  = 16;
    localparam int DEF_ADDR_W = 14;
    localparam int DEF_RD_LAT = 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    typedef logic [1:0] tap_idx_t;
endpackage

// File: rtl/maxpool2x2_mem_if.sv
// rtl/maxpool2x2_mem_if.sv - scratch RAM read/write port bundle
interface maxpool2x2_mem_if
    import cnn_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;

    modport master (output rd_addr, output wr_addr, output wr_data, output wr_en, input rd_data);
    modport slave  (input rd_addr, input wr_addr, input wr_data, input wr_en, output rd_data);
endinterface

// File: rtl/maxpool_addr_gen.sv
// rtl/maxpool_addr_gen.sv - window/tap source addressing and destination pointer
module maxpool_addr_gen
    import cnn_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DIM_W  = DEF_DIM_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              load,
    input  logic              tap_adv,
    input  logic              win_adv,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    output logic [ADDR_W-1:0] tap_addr,
    output logic [ADDR_W-1:0] dst_ptr,
    output tap_idx_t          tap,
    output logic              last_tap,
    output logic              last_window,
    output logic              empty
);
    localparam logic [DIM_W-2:0]  ONE_D = 1;
    localparam logic [ADDR_W-1:0] ONE_A = 1;
    localparam logic [ADDR_W-1:0] TWO_A = 2;

    logic [ADDR_W-1:0] w_q, row_base, win_base, two_w;
    logic [DIM_W-2:0]  ow_q, oh_q, ox, oy;

    // Only the low ADDR_W bits of W matter: all address arithmetic wraps.
    assign two_w = {w_q[ADDR_W-2:0], 1'b0};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_q      <= '0;
            ow_q     <= '0;
            oh_q     <= '0;
            ox       <= '0;
            oy       <= '0;
            row_base <= '0;
            win_base <= '0;
            dst_ptr  <= '0;
            tap      <= '0;
        end else if (enable) begin
            if (load) begin
                w_q      <= width[ADDR_W-1:0];
                ow_q     <= width[DIM_W-1:1];
                oh_q     <= height[DIM_W-1:1];
                ox       <= '0;
                oy       <= '0;
                row_base <= src_base;
                win_base <= src_base;
                dst_ptr  <= dst_base;
                tap      <= '0;
            end else begin
                if (tap_adv)
                    tap <= tap + 2'd1;
                if (win_adv) begin
                    dst_ptr <= dst_ptr + ONE_A;
                    if (ox == ow_q - ONE_D) begin
                        ox       <= '0;
                        oy       <= oy + ONE_D;
                        row_base <= row_base + two_w;
                        win_base <= row_base + two_w;
                    end else begin
                        ox       <= ox + ONE_D;
                        win_base <= win_base + TWO_A;
                    end
                end
            end
        end
    end

    always_comb begin
        tap_addr = win_base;
        case (tap)
            2'd0: tap_addr = win_base;
            2'd1: tap_addr = win_base + ONE_A;
            2'd2: tap_addr = win_base + w_q;
            2'd3: tap_addr = win_base + w_q + ONE_A;
            default: tap_addr = win_base;
        endcase
    end

    assign last_tap    = (tap == 2'd3);
    assign last_window = (ox == ow_q - ONE_D) && (oy == oh_q - ONE_D);
    assign empty       = (ow_q == '0) || (oh_q == '0);
endmodule

// File: rtl/maxpool2x2_mem.sv
// rtl/maxpool2x2_mem.sv - memory-to-memory 2x2 stride-2 signed max-pooling stage
module maxpool2x2_mem
    import cnn_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DIM_W  = DEF_DIM_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    maxpool2x2_mem_if.master  mem,
    output logic              busy,
    output logic              done
);
    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

    logic [2:0]               state, lat_cnt;
    logic                     stalled, launch, capture;
    logic signed [DATA_W-1:0] max_q;
    logic [ADDR_W-1:0]        tap_addr, dst_ptr;
    tap_idx_t                 tap;
    logic                     last_tap, last_window, empty;

    assign launch  = ((state == S_IDLE) || (state == S_DONE)) && start;
    assign capture = (state == S_WAIT) && !stalled && (lat_cnt == LAT_LAST);

    maxpool_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .load        (launch),
        .tap_adv     (capture),
        .win_adv     (state == S_WRITE),
        .src_base    (src_base),
        .dst_base    (dst_base),
        .width       (width),
        .height      (height),
        .tap_addr    (tap_addr),
        .dst_ptr     (dst_ptr),
        .tap         (tap),
        .last_tap    (last_tap),
        .last_window (last_window),
        .empty       (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            lat_cnt <= '0;
            stalled <= 1'b0;
            max_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (!enable) begin
            // The RAM pipeline keeps moving while frozen, so the in-flight read is discarded.
            if (state == S_WAIT)
                stalled <= 1'b1;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_LAUNCH;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    if (empty) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state   <= S_WAIT;
                    lat_cnt <= '0;
                end
                S_WAIT: begin
                    if (stalled) begin
                        stalled <= 1'b0;
                        state   <= S_ISSUE;
                    end else if (lat_cnt == LAT_LAST) begin
                        // Strictly greater only, so ties keep the earlier tap.
                        if ((tap == 2'd0) || ($signed(mem.rd_data) > max_q))
                            max_q <= $signed(mem.rd_data);
                        state <= last_tap ? S_WRITE : S_ISSUE;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                S_WRITE: begin
                    if (last_window) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem.rd_addr = tap_addr;
    assign mem.wr_addr = dst_ptr;
    assign mem.wr_data = max_q;
    assign mem.wr_en   = (state == S_WRITE) && enable;
endmodule
